k12a_spi_slave: RTL and testbench



---
 rtl/k12a_spi_slave_if.sv | 27 ++
 rtl/k12a_spi_slave.sv | 123 ++++++++++++
 tb/tb_k12a_spi_slave.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/k12a_spi_slave_if.sv
// Pin and CPU-side signal bundle for the k12a SPI responder.
// The slave modport is the responder's view; master is the view of whoever drives it.
interface k12a_spi_slave_if;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       busy;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, tx_data, tx_write, rx_ack,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, tx_data, tx_write, rx_ack,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );
endinterface

// File: rtl/k12a_spi_slave.sv
// SPI mode-0 responder: oversamples SCK/MOSI/CS_n in cpu_clock, MSB-first 8-bit frames,
// one-byte transmit buffer and one-byte receive holding register with sticky overrun.
module k12a_spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic            cpu_clock,
  input  logic            reset,
  k12a_spi_slave_if.slave bus
);

  // NOTE: two flops per pin settle metastability; the third stage on sck/cs_n is only the
  // previous synchronized value used for edge detection, never a raw-pin view.
  logic [2:0] sck_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic [7:0] tx_buf;
  logic       tx_full;
  logic [7:0] tx_shift;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;

  logic sck_s, sck_d, cs_s, cs_d, mosi_s;
  logic cs_rise, cs_fall, sck_rise, sck_fall;
  logic load, byte_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], bus.spi_sck};
      cs_sync   <= {cs_sync[1:0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
    end
  end

  assign sck_s  = sck_sync[1];
  assign sck_d  = sck_sync[2];
  assign cs_s   = cs_sync[1];
  assign cs_d   = cs_sync[2];
  assign mosi_s = mosi_sync[1];

  // CS_n edges take priority; SCK edges count only while CS_n was and still is low.
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign sck_rise  = ~cs_s & ~cs_d & sck_s & ~sck_d;
  assign sck_fall  = ~cs_s & ~cs_d & ~sck_s & sck_d;
  assign load      = cs_fall | (sck_fall & (bit_cnt == 3'd0));
  assign byte_done = sck_rise & (bit_cnt == 3'd7);

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
    end else if (cs_rise) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
    end else if (cs_fall) begin
      bit_cnt  <= 3'd0;
    end else if (sck_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[5:0], mosi_s};
    end
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      tx_shift <= 8'h00;
    end else if (load) begin
      tx_shift <= tx_full ? tx_buf : IDLE_BYTE;
    end else if (sck_fall) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // A write accepted at a load point must survive the load's clear, so it is ordered last.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
    end else begin
      if (load) tx_full <= 1'b0;
      if (bus.tx_write && !tx_full) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (bus.rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (byte_done) begin
        rx_data  <= {rx_shift, mosi_s};
        rx_valid <= 1'b1;
        if (rx_valid && !bus.rx_ack) rx_overrun <= 1'b1;
      end
    end
  end

  assign bus.spi_miso    = tx_shift[7];
  assign bus.spi_miso_oe = ~cs_d;
  assign bus.busy        = ~cs_d;
  assign bus.tx_ready    = ~tx_full;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_overrun  = rx_overrun;

endmodule

// File: tb/tb_k12a_spi_slave.sv
// Bench for k12a_spi_slave: a bit-banged mode-0 master with a byte-level reference model;
// expected bytes are queued at stimulus time and popped by independent MISO and RX monitors.
module tb_k12a_spi_slave;

  logic cpu_clock;
  logic reset;
  k12a_spi_slave_if bus ();

  k12a_spi_slave #(.IDLE_BYTE(8'hFF)) dut (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .bus       (bus)
  );

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  int cyc_cnt = 0;
  always @(posedge cpu_clock) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: transmit buffer contents and the two expected-byte streams.
  bit         m_full;
  logic [7:0] m_buf;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  bit         auto_ack;
  int         ack_at;
  logic [7:0] mosi_b[4];
  bit         wr_en[4];
  logic [7:0] wr_val[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  function automatic bit observed(input int b, input int nbytes, input int stop_rises);
    return (stop_rises < 0) ? (b < nbytes) : ((b + 1) * 8 <= stop_rises);
  endfunction

  // A load point empties the buffer; the byte is expected on MISO only if fully clocked out.
  task automatic model_load(input bit obs, output logic [7:0] v);
    v      = m_full ? m_buf : 8'hFF;
    m_full = 1'b0;
    if (obs) tx_exp.push_back(v);
  endtask

  task automatic cpu_write(input logic [7:0] v);
    check("tx_ready_before_write", 32'(bus.tx_ready), 32'(!m_full));
    bus.tx_data  = v;
    bus.tx_write = 1'b1;
    if (!m_full) begin
      m_buf  = v;
      m_full = 1'b1;
    end
    cyc(1);
    bus.tx_write = 1'b0;
  endtask

  task automatic do_ack();
    ack_at = cyc_cnt + 1;
    cyc(3);
  endtask

  task automatic new_bytes();
    for (int b = 0; b < 4; b++) begin
      mosi_b[b] = 8'($urandom);
      wr_en[b]  = 1'b0;
      wr_val[b] = 8'($urandom);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_miso"},       32'(bus.spi_miso),    32'h0);
    check({tag, "_miso_oe"},    32'(bus.spi_miso_oe), 32'h0);
    check({tag, "_tx_ready"},   32'(bus.tx_ready),    32'h1);
    check({tag, "_rx_data"},    32'(bus.rx_data),     32'h0);
    check({tag, "_rx_valid"},   32'(bus.rx_valid),    32'h0);
    check({tag, "_rx_overrun"}, 32'(bus.rx_overrun),  32'h0);
    check({tag, "_busy"},       32'(bus.busy),        32'h0);
  endtask

  // One CS_n assertion. stop_rises >= 0 ends the frame early, by CS_n rise or by reset.
  task automatic frame(input int nbytes, input int h, input int stop_rises,
                       input bit by_reset, input bit check_lat, input bit ack_last);
    int         total;
    int         b;
    logic [7:0] ld;
    total = (stop_rises < 0) ? nbytes * 8 : stop_rises;
    bus.spi_mosi = mosi_b[0][7];
    bus.spi_cs_n = 1'b0;
    model_load(observed(0, nbytes, stop_rises), ld);
    if (check_lat) begin
      cyc(2);
      check("busy_before_lag", 32'(bus.busy), 32'h0);
      cyc(1);
      check("busy_after_lag",     32'(bus.busy),        32'h1);
      check("miso_oe_after_lag",  32'(bus.spi_miso_oe), 32'h1);
      check("miso_msb_after_cs",  32'(bus.spi_miso),    32'(ld[7]));
      check("tx_ready_after_cs",  32'(bus.tx_ready),    32'h1);
      cyc(h - 3);
    end else begin
      cyc(h);
    end
    for (int r = 1; r <= total; r++) begin
      b = (r - 1) / 8;
      bus.spi_sck = 1'b1;
      if (r % 8 == 0) begin
        if (auto_ack) rx_exp.push_back(mosi_b[b]);
        if (ack_last && r == total) ack_at = cyc_cnt + 2;
      end
      if (check_lat && r == total) begin
        cyc(2);
        check("rx_valid_before_lag", 32'(bus.rx_valid), 32'h0);
        cyc(1);
        check("rx_valid_after_lag", 32'(bus.rx_valid), 32'h1);
        check("rx_data_after_lag",  32'(bus.rx_data),  32'(mosi_b[b]));
        cyc(h - 3);
      end else if (wr_en[b] && r % 8 == 3) begin
        cpu_write(wr_val[b]);
        cyc(h - 1);
      end else begin
        cyc(h);
      end
      bus.spi_sck = 1'b0;
      if (r % 8 == 0) model_load(observed(b + 1, nbytes, stop_rises), ld);
      if (r < total) bus.spi_mosi = mosi_b[r / 8][7 - r % 8];
      cyc(h);
    end
    if (by_reset) begin
      reset        = 1'b1;
      bus.spi_cs_n = 1'b1;
      m_full       = 1'b0;
      cyc(2);
      check_idle("reset_mid_byte");
      reset = 1'b0;
    end else begin
      bus.spi_cs_n = 1'b1;
    end
    cyc(h + 2);
  endtask

  // MISO monitor: assembles what the master samples at each SCK rise.
  initial begin : miso_monitor
    int         cnt;
    logic [7:0] sh;
    cnt = 0;
    sh  = 8'h00;
    forever begin
      @(posedge bus.spi_sck or posedge bus.spi_cs_n);
      if (bus.spi_cs_n) begin
        cnt = 0;
      end else begin
        sh = {sh[6:0], bus.spi_miso};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected_byte: got %02h, none expected", sh);
          end else begin
            check("miso_byte", 32'(sh), 32'(tx_exp.pop_front()));
          end
        end
      end
    end
  end

  // RX monitor and sole driver of rx_ack: scheduled acks, or auto-ack of each presented byte.
  initial begin : rx_monitor
    bus.rx_ack = 1'b0;
    forever begin
      @(negedge cpu_clock);
      if (cyc_cnt == ack_at) begin
        bus.rx_ack = 1'b1;
      end else if (auto_ack && bus.rx_valid && !bus.rx_ack) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_byte: got %02h, none expected", bus.rx_data);
        end else begin
          check("rx_byte", 32'(bus.rx_data), 32'(rx_exp.pop_front()));
          check("rx_no_overrun", 32'(bus.rx_overrun), 32'h0);
        end
        bus.rx_ack = 1'b1;
      end else begin
        bus.rx_ack = 1'b0;
      end
    end
  end

  initial begin : stimulus
    reset        = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_write = 1'b0;
    auto_ack     = 1'b0;
    ack_at       = -1;
    m_full       = 1'b0;
    m_buf        = 8'h00;
    new_bytes();
    cyc(3);
    check_idle("reset");
    reset = 1'b0;
    cyc(2);

    // Single byte with latency checks on CS_n fall and the 8th SCK rise.
    cpu_write(8'hA5);
    new_bytes();
    mosi_b[0] = 8'h3C;
    frame(1, 4, -1, 1'b0, 1'b1, 1'b0);
    check("single_rx_data",    32'(bus.rx_data),    32'h3C);
    check("single_rx_valid",   32'(bus.rx_valid),   32'h1);
    check("single_rx_overrun", 32'(bus.rx_overrun), 32'h0);
    do_ack();
    check("single_ack_clears", 32'(bus.rx_valid), 32'h0);

    // Two bytes, with and without a refill during the first byte.
    auto_ack = 1'b1;
    cpu_write(8'hA5);
    new_bytes();
    wr_en[0]  = 1'b1;
    wr_val[0] = 8'h5A;
    frame(2, 4, -1, 1'b0, 1'b0, 1'b0);
    cpu_write(8'hA5);
    new_bytes();
    frame(2, 4, -1, 1'b0, 1'b0, 1'b0);

    // Write while full: the second write is dropped.
    cpu_write(8'h11);
    cpu_write(8'h22);
    new_bytes();
    frame(1, 4, -1, 1'b0, 1'b0, 1'b0);

    // Overrun, then ack coincident with completion.
    auto_ack = 1'b0;
    new_bytes();
    mosi_b[0] = 8'h12;
    mosi_b[1] = 8'h34;
    frame(2, 4, -1, 1'b0, 1'b0, 1'b0);
    check("overrun_rx_data",  32'(bus.rx_data),    32'h34);
    check("overrun_rx_valid", 32'(bus.rx_valid),   32'h1);
    check("overrun_flag_set", 32'(bus.rx_overrun), 32'h1);
    do_ack();
    check("overrun_ack_valid", 32'(bus.rx_valid),   32'h0);
    check("overrun_ack_flag",  32'(bus.rx_overrun), 32'h0);
    new_bytes();
    mosi_b[0] = 8'h56;
    frame(1, 4, -1, 1'b0, 1'b0, 1'b0);
    new_bytes();
    mosi_b[0] = 8'h78;
    frame(1, 4, -1, 1'b0, 1'b0, 1'b1);
    check("coincident_rx_data",  32'(bus.rx_data),    32'h78);
    check("coincident_rx_valid", 32'(bus.rx_valid),   32'h1);
    check("coincident_overrun",  32'(bus.rx_overrun), 32'h0);
    do_ack();

    // Abort after 5 rises: loaded tx byte lost, no rx byte, next frame realigned.
    cpu_write(8'h77);
    new_bytes();
    frame(1, 4, 5, 1'b0, 1'b0, 1'b0);
    check("abort_no_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("abort_tx_ready",    32'(bus.tx_ready), 32'h1);
    new_bytes();
    mosi_b[0] = 8'hC3;
    frame(1, 5, -1, 1'b0, 1'b0, 1'b0);
    check("after_abort_rx_data",  32'(bus.rx_data),  32'hC3);
    check("after_abort_rx_valid", 32'(bus.rx_valid), 32'h1);
    do_ack();

    // Reset after 3 bits, then a normal frame.
    cpu_write(8'h99);
    new_bytes();
    frame(1, 4, 3, 1'b1, 1'b0, 1'b0);
    auto_ack = 1'b1;
    cpu_write(8'hE7);
    new_bytes();
    frame(1, 4, -1, 1'b0, 1'b0, 1'b0);

    // Randomized frames: length, SCK half period, payloads and buffer writes.
    for (int f = 0; f < 24; f++) begin
      new_bytes();
      for (int b = 0; b < 4; b++) wr_en[b] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) cpu_write(8'($urandom));
      frame($urandom_range(1, 3), $urandom_range(4, 6), -1, 1'b0, 1'b0, 1'b0);
    end

    cyc(10);
    check("tx_expected_drained", 32'(tx_exp.size()), 32'h0);
    check("rx_expected_drained", 32'(rx_exp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
